intr_timer_ctrl: RTL and testbench
==================================

# intr_timer_ctrl

Machine-mode interrupt source block: a memory-mapped 64-bit machine timer (mtime/mtimecmp), a software-interrupt register (msip), and an external-interrupt synchronizer, feeding an arbiter/issue state machine. It sits directly upstream of the CSR block and drives its `g_interrupt` / `g_interrupt_priv` inputs. It uses the CSR block's `csr_meie` / `csr_mtie` / `csr_msie` outputs and the mstatus.MIE bit, which the CSR block must export as `csr_mstatus_mie`. Software reaches the timer and msip through a simple single-cycle data-bus slave port.

## Interface
- `TICK_DIV`, default 1: clock cycles per mtime increment; legal range 1..65535.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `bus_cs` in 1: slave select, one-cycle request.
- `bus_we` in 1: 1 = write, 0 = read.
- `bus_adr` in 3: word address (byte address bits [4:2]).
- `bus_wdata` in 32: write data.
- `bus_rdata` out 32: read data, valid the cycle after a read request.
- `ext_irq` in 1: asynchronous level external interrupt, active-high.
- `csr_mstatus_mie` in 1: global machine interrupt enable.
- `csr_meie`, `csr_mtie`, `csr_msie` in 1 each: per-source enables.
- `cpu_stat_ex` in 1: EX stage holds a valid instruction that can accept a trap.
- `g_interrupt` out 1: interrupt taken, one-cycle pulse.
- `g_interrupt_priv` out 2: constant 2'b11 (M-mode).
- `g_interrupt_cause` out 4: cause of the current or last issued interrupt: 11 = MEI, 3 = MSI, 7 = MTI.
- `mip_bits` out 3: {meip, mtip, msip} raw pending bits, for future mip read-back.

## Operation
- **Address map** (`bus_adr`): 0 = mtime[31:0], 1 = mtime[63:32], 2 = mtimecmp[31:0], 3 = mtimecmp[63:32], 4 = msip (bit 0; bits [31:1] read 0, writes ignored). Addresses 5..7 read 0; writes to them are ignored.
- **Prescaler:** 16-bit counter. Counts 0..TICK_DIV-1 and wraps. A tick fires on the wrap cycle.
- **mtime:** increments by 1 on each tick and wraps 2^64-1 -> 0.
  - A bus write to either mtime half in the same cycle as a tick wins. The written half takes the written value; the other half holds its value with no carry.
- **mtip:** registered, = (mtime >= mtimecmp), unsigned 64-bit compare, updated every cycle.
- **meip:** 2-flop synchronizer on `ext_irq`. Level-sensitive, not latched.
- **msip:** software-writable register bit.
- **Enabled pending:** en_pend = {meip & csr_meie, msip & csr_msie, mtip & csr_mtie}.
- **Priority:** fixed MEI > MSI > MTI.
- **Issue FSM:**
  - IDLE -> ISSUE when csr_mstatus_mie & |en_pend. Latch the winning cause into `g_interrupt_cause`.
  - ISSUE: g_interrupt = cpu_stat_ex.
    - If cpu_stat_ex = 1: -> WAIT.
    - If cpu_stat_ex = 0: hold ISSUE.
    - Cancel to IDLE, with no pulse, if csr_mstatus_mie = 0 or the latched cause's en_pend bit is 0. Cancel takes precedence over cpu_stat_ex.
  - WAIT: one cycle, no issue, so the CSR block's clearing of MIE becomes visible. Then -> IDLE.
- A source still pending after return re-triggers normally. No pulse occurs while mstatus.MIE = 0.

## Timing
- **Reset values:** mtime = 0, prescaler = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF (no spurious MTI), msip = 0, synchronizer flops = 0, FSM = IDLE, bus_rdata = 0, g_interrupt = 0, g_interrupt_cause = 0, mip_bits = 0.
  - Reset asserted mid-ISSUE or mid-WAIT returns to IDLE next cycle with no pulse.
- **Bus writes:** take effect at the clock edge ending the request cycle. **Bus reads:** registered, so bus_rdata is valid exactly 1 cycle after the request and holds until the next read.
  - A read and a write to the same register in the same cycle are impossible (single port). A read returns the pre-write value of the previous cycle.
- **mtip latency:** mtime or mtimecmp change -> mtip updates 1 cycle later -> FSM enters ISSUE the following cycle.
- **ext_irq latency:** ext_irq rise -> meip after 2 clocks -> earliest g_interrupt 2 clocks after that (IDLE->ISSUE, then ISSUE with cpu_stat_ex = 1).
- `g_interrupt` is combinational from FSM state & cpu_stat_ex. It is never high in two consecutive cycles, and the minimum spacing is 3 cycles.
- **Simultaneous sources:** the highest priority wins. The latched cause does not change while in ISSUE, even if a higher-priority source arrives.

## Structure
- **Shared package:** constants for the address map (ADR_MTIME_LO..ADR_MSIP), the cause codes (CAUSE_MEI = 11, CAUSE_MSI = 3, CAUSE_MTI = 7), and M_MODE = 2'b11. The CSR block's mcause logic moves to consuming `g_interrupt_cause` from this package.
- **Sub-module:** `mtimer`, containing the prescaler, mtime, mtimecmp, the compare, and the bus decode for addresses 0..3.
- **Top level:** synchronizer, msip, arbiter, FSM, and the read mux.

## Test plan
- **Reset:** reset, then read mtimecmp hi -> 0xFFFFFFFF. Read mtime after 10 cycles with TICK_DIV = 1 -> roughly 10. g_interrupt stays 0 throughout.
- **Timer interrupt:** write mtimecmp = 20 with csr_mtie = 1, csr_mstatus_mie = 1, cpu_stat_ex = 1 -> a single g_interrupt pulse with cause 7 at mtime ≈ 22. No second pulse once csr_mstatus_mie drops the cycle after.
- **Priority:** msip = 1 and ext_irq = 1 together, all enables set -> cause 11 issued first. After MIE is restored with ext_irq low -> cause 3 issued.
- **Hold and cancel:** pending MSI with cpu_stat_ex = 0 for 5 cycles -> no pulse, FSM holds ISSUE. cpu_stat_ex = 1 -> pulse. Repeat, but write msip = 0 while held -> cancel, no pulse.
- **Prescaler and wrap:** TICK_DIV = 4, mtime written to 64'hFFFF_FFFF_FFFF_FFFE -> after 8 cycles mtime = 0, and mtime hi wraps correctly.
- **Tick/write collision:** bus write mtime lo = 0x100 on a tick cycle -> mtime lo reads 0x100 and the hi half is unchanged.

Source files
------------

// File: rtl/intr_timer_ctrl_pkg.sv
// intr_timer_ctrl_pkg
// Shared constants for the machine-mode interrupt source block and its
// consumers (the CSR block takes its mcause value from g_interrupt_cause,
// so it uses the cause codes defined here).
//   - bus word address map for mtime / mtimecmp / msip
//   - interrupt cause codes and the privilege level driven with every trap
//   - issue FSM state encoding
//   - helpers for fixed-priority arbitration and pending-bit lookup
package intr_timer_ctrl_pkg;

   localparam logic [2:0] ADR_MTIME_LO    = 3'd0;
   localparam logic [2:0] ADR_MTIME_HI    = 3'd1;
   localparam logic [2:0] ADR_MTIMECMP_LO = 3'd2;
   localparam logic [2:0] ADR_MTIMECMP_HI = 3'd3;
   localparam logic [2:0] ADR_MSIP        = 3'd4;

   localparam logic [3:0] CAUSE_MEI = 4'd11;
   localparam logic [3:0] CAUSE_MSI = 4'd3;
   localparam logic [3:0] CAUSE_MTI = 4'd7;

   localparam logic [1:0] M_MODE = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } issue_st_e;

   // en_pend layout: {mei, msi, mti}; fixed priority MEI > MSI > MTI.
   function automatic logic [3:0] pick_cause(input logic [2:0] en_pend);
      logic [3:0] c;
      c = CAUSE_MTI;
      if (en_pend[2])      c = CAUSE_MEI;
      else if (en_pend[1]) c = CAUSE_MSI;
      return c;
   endfunction

   // Is the source behind a latched cause code still enabled and pending?
   function automatic logic cause_pending(input logic [3:0] cause,
                                          input logic [2:0] en_pend);
      logic p;
      p = 1'b0;
      case (cause)
         CAUSE_MEI: p = en_pend[2];
         CAUSE_MSI: p = en_pend[1];
         CAUSE_MTI: p = en_pend[0];
         default:   p = 1'b0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/intr_timer_ctrl_mtimer.sv
// mtimer
// 64-bit machine timer: prescaler, mtime, mtimecmp, registered compare and
// the bus write decode for word addresses 0..3.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   bus_cs, bus_we, bus_adr       slave request (write decode only here)
//   bus_wdata                     write data
//   mtime, mtimecmp               current register values (for read mux)
//   mtip                          registered mtime >= mtimecmp
module mtimer
   import intr_timer_ctrl_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_cs,
   input  logic        bus_we,
   input  logic [2:0]  bus_adr,
   input  logic [31:0] bus_wdata,
   output logic [63:0] mtime,
   output logic [63:0] mtimecmp,
   output logic        mtip
);

   localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

   logic [15:0] presc;
   logic        tick;
   logic        wr;

   assign tick = (presc == PRESC_MAX);
   assign wr   = bus_cs & bus_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         presc    <= '0;
         mtime    <= '0;
         mtimecmp <= '1;
         mtip     <= 1'b0;
      end else begin
         presc <= tick ? 16'd0 : presc + 16'd1;

         // A write to either half beats a coincident tick; the other half
         // is left alone, so no carry crosses into it.
         if (wr && bus_adr == ADR_MTIME_LO)
            mtime[31:0] <= bus_wdata;
         else if (wr && bus_adr == ADR_MTIME_HI)
            mtime[63:32] <= bus_wdata;
         else if (tick)
            mtime <= mtime + 64'd1;

         if (wr && bus_adr == ADR_MTIMECMP_LO)
            mtimecmp[31:0] <= bus_wdata;
         if (wr && bus_adr == ADR_MTIMECMP_HI)
            mtimecmp[63:32] <= bus_wdata;

         mtip <= (mtime >= mtimecmp);
      end
   end

endmodule

// File: rtl/intr_timer_ctrl.sv
// intr_timer_ctrl
// Machine-mode interrupt source: timer (via mtimer), software interrupt bit,
// external interrupt synchronizer, fixed-priority arbiter and issue FSM
// feeding the CSR block's trap inputs.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   bus_cs/we/adr/wdata, bus_rdata   single-cycle slave, registered reads
//   ext_irq                          async level external interrupt
//   csr_mstatus_mie                  global machine interrupt enable
//   csr_meie/mtie/msie               per-source enables
//   cpu_stat_ex                      EX stage can take a trap this cycle
//   g_interrupt                      trap taken (one-cycle pulse)
//   g_interrupt_priv                 always M-mode
//   g_interrupt_cause                cause of current/last issued interrupt
//   mip_bits                         raw pending {meip, mtip, msip}
module intr_timer_ctrl
   import intr_timer_ctrl_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_cs,
   input  logic        bus_we,
   input  logic [2:0]  bus_adr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   input  logic        ext_irq,
   input  logic        csr_mstatus_mie,
   input  logic        csr_meie,
   input  logic        csr_mtie,
   input  logic        csr_msie,
   input  logic        cpu_stat_ex,
   output logic        g_interrupt,
   output logic [1:0]  g_interrupt_priv,
   output logic [3:0]  g_interrupt_cause,
   output logic [2:0]  mip_bits
);

   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        mtip;
   logic [1:0]  ext_sync;
   logic        meip;
   logic        msip;
   logic [2:0]  en_pend;
   logic        cancel;
   logic        load_cause;
   issue_st_e   state_q, state_d;

   mtimer #(.TICK_DIV(TICK_DIV)) u_mtimer (
      .clk      (clk),
      .rst      (rst),
      .bus_cs   (bus_cs),
      .bus_we   (bus_we),
      .bus_adr  (bus_adr),
      .bus_wdata(bus_wdata),
      .mtime    (mtime),
      .mtimecmp (mtimecmp),
      .mtip     (mtip)
   );

   // ext_irq is asynchronous; two flops before anything looks at it.
   always_ff @(posedge clk) begin
      if (rst) begin
         ext_sync <= '0;
         msip     <= 1'b0;
      end else begin
         ext_sync <= {ext_sync[0], ext_irq};
         if (bus_cs && bus_we && bus_adr == ADR_MSIP)
            msip <= bus_wdata[0];
      end
   end

   assign meip     = ext_sync[1];
   assign mip_bits = {meip, mtip, msip};
   assign en_pend  = {meip & csr_meie, msip & csr_msie, mtip & csr_mtie};

   // Registered read mux; holds its value between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus_rdata <= '0;
      end else if (bus_cs && !bus_we) begin
         case (bus_adr)
            ADR_MTIME_LO:    bus_rdata <= mtime[31:0];
            ADR_MTIME_HI:    bus_rdata <= mtime[63:32];
            ADR_MTIMECMP_LO: bus_rdata <= mtimecmp[31:0];
            ADR_MTIMECMP_HI: bus_rdata <= mtimecmp[63:32];
            ADR_MSIP:        bus_rdata <= {31'd0, msip};
            default:         bus_rdata <= '0;
         endcase
      end
   end

   // Issue FSM. rst is folded into cancel so a reset cycle landing in ISSUE
   // cannot leak a pulse before the state register clears.
   assign cancel = rst | ~csr_mstatus_mie | ~cause_pending(g_interrupt_cause, en_pend);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= ST_IDLE;
         g_interrupt_cause <= '0;
      end else begin
         state_q <= state_d;
         if (load_cause)
            g_interrupt_cause <= pick_cause(en_pend);
      end
   end

   always_comb begin
      state_d     = state_q;
      load_cause  = 1'b0;
      g_interrupt = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (csr_mstatus_mie && |en_pend) begin
               state_d    = ST_ISSUE;
               load_cause = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (cancel) begin
               state_d = ST_IDLE;
            end else if (cpu_stat_ex) begin
               g_interrupt = 1'b1;
               state_d     = ST_WAIT;
            end
         end
         // One dead cycle so the CSR block's MIE clear is visible here.
         ST_WAIT: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign g_interrupt_priv = M_MODE;

endmodule

// File: tb/tb_intr_timer_ctrl.sv
module tb_intr_timer_ctrl;
   import intr_timer_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst, bus_cs, bus_we, ext_irq;
   logic [2:0]  bus_adr;
   logic [31:0] bus_wdata;
   logic        mie, meie, mtie, msie, cpu_stat_ex;
   logic        tie0 = 1'b0;

   logic [31:0] rdata1, rdata4;
   logic        g_int, g_int4;
   logic [1:0]  priv, priv4;
   logic [3:0]  cause, cause4;
   logic [2:0]  mip, mip4;

   always #5 clk = ~clk;

   intr_timer_ctrl #(.TICK_DIV(1)) u_dut (
      .clk(clk), .rst(rst), .bus_cs(bus_cs), .bus_we(bus_we), .bus_adr(bus_adr),
      .bus_wdata(bus_wdata), .bus_rdata(rdata1), .ext_irq(ext_irq),
      .csr_mstatus_mie(mie), .csr_meie(meie), .csr_mtie(mtie), .csr_msie(msie),
      .cpu_stat_ex(cpu_stat_ex), .g_interrupt(g_int), .g_interrupt_priv(priv),
      .g_interrupt_cause(cause), .mip_bits(mip)
   );

   // Second instance exercises the prescaler; shares the bus, interrupts idle.
   intr_timer_ctrl #(.TICK_DIV(4)) u_div4 (
      .clk(clk), .rst(rst), .bus_cs(bus_cs), .bus_we(bus_we), .bus_adr(bus_adr),
      .bus_wdata(bus_wdata), .bus_rdata(rdata4), .ext_irq(tie0),
      .csr_mstatus_mie(tie0), .csr_meie(tie0), .csr_mtie(tie0), .csr_msie(tie0),
      .cpu_stat_ex(tie0), .g_interrupt(g_int4), .g_interrupt_priv(priv4),
      .g_interrupt_cause(cause4), .mip_bits(mip4)
   );

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic        sel4;
      string       name;
   } rd_exp_t;

   rd_exp_t     rd_q[$];
   logic [3:0]  int_q[$];
   int          errors = 0;
   int          checks = 0;
   logic        rd_seen = 1'b0;
   rd_exp_t     mon_e;
   logic [3:0]  mon_c;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] lo, input logic [31:0] hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h..0x%0h", name, act, lo, hi);
      end
   endtask

   // Monitor: a read response appears the cycle after the request; every
   // g_interrupt pulse must match the next queued cause.
   always @(posedge clk) rd_seen <= bus_cs && !bus_we && !rst;

   always @(negedge clk) begin
      if (rd_seen) begin
         if (rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected: got 0x%0h, want no response", rdata1);
         end else begin
            mon_e = rd_q.pop_front();
            chk(mon_e.name, mon_e.sel4 ? rdata4 : rdata1, mon_e.lo, mon_e.hi);
         end
      end
      if (g_int) begin
         if (int_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pulse: got cause %0d, want no pulse", cause);
         end else begin
            mon_c = int_q.pop_front();
            chk("irq_cause", {28'd0, cause}, {28'd0, mon_c}, {28'd0, mon_c});
         end
      end
   end

   // All tasks start and end #1 after a rising edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      bus_cs = 1'b1; bus_we = 1'b1; bus_adr = a; bus_wdata = d;
      step(1);
      bus_cs = 1'b0; bus_we = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, input logic [31:0] lo,
                           input logic [31:0] hi, input logic sel4, input string name);
      rd_exp_t e;
      e.lo = lo; e.hi = hi; e.sel4 = sel4; e.name = name;
      rd_q.push_back(e);
      bus_cs = 1'b1; bus_we = 1'b0; bus_adr = a;
      step(1);
      bus_cs = 1'b0;
   endtask

   // Returns in the cycle after the pulse (FSM in WAIT).
   task automatic wait_pulse(input string name);
      bit got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (g_int) got = 1'b1;
      end
      step(1);
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s: pulse seen 0, want 1", name);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; bus_cs = 1'b0; bus_we = 1'b0; bus_adr = '0; bus_wdata = '0;
      ext_irq = 1'b0; mie = 1'b0; meie = 1'b0; mtie = 1'b0; msie = 1'b0;
      cpu_stat_ex = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rdata", rdata1, 0, 0);
      chk("rst_g_int", {31'd0, g_int}, 0, 0);
      chk("rst_cause", {28'd0, cause}, 0, 0);
      chk("rst_mip", {29'd0, mip}, 0, 0);
      chk("priv", {30'd0, priv}, 3, 3);
      @(posedge clk); #1;
      rst = 1'b0;
      bus_read(ADR_MTIMECMP_HI, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "rst_cmp_hi");
      bus_read(ADR_MTIMECMP_LO, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "rst_cmp_lo");
      step(8);
      bus_read(ADR_MTIME_LO, 8, 14, 1'b0, "mtime_count");
      bus_read(ADR_MTIME_HI, 0, 0, 1'b0, "mtime_hi_zero");

      // Timer interrupt: mtime restarted at 0, mtimecmp = 20
      mtie = 1'b1; mie = 1'b1; cpu_stat_ex = 1'b1;
      int_q.push_back(CAUSE_MTI);
      bus_write(ADR_MTIME_LO, 0);
      bus_write(ADR_MTIMECMP_LO, 20);
      bus_write(ADR_MTIMECMP_HI, 0);
      wait_pulse("mti_pulse");
      mie = 1'b0;
      bus_read(ADR_MTIME_LO, 22, 25, 1'b0, "mti_time");
      chk("mtip_raw", {31'd0, mip[1]}, 1, 1);
      step(10);
      mtie = 1'b0;
      bus_write(ADR_MTIMECMP_HI, 32'hFFFF_FFFF);

      // Priority: MEI before MSI
      msie = 1'b1; meie = 1'b1;
      bus_write(ADR_MSIP, 1);
      ext_irq = 1'b1;
      step(4);
      chk("meip_sync", {31'd0, mip[2]}, 1, 1);
      chk("msip_bit", {31'd0, mip[0]}, 1, 1);
      int_q.push_back(CAUSE_MEI);
      int_q.push_back(CAUSE_MSI);
      mie = 1'b1;
      wait_pulse("mei_pulse");
      mie = 1'b0; ext_irq = 1'b0;
      step(5);
      chk("meip_drop", {31'd0, mip[2]}, 0, 0);
      mie = 1'b1;
      wait_pulse("msi_pulse");
      mie = 1'b0;
      step(3);

      // Hold in ISSUE, then release
      cpu_stat_ex = 1'b0;
      int_q.push_back(CAUSE_MSI);
      mie = 1'b1;
      step(1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_no_pulse", {31'd0, g_int}, 0, 0);
      end
      step(1);
      cpu_stat_ex = 1'b1;
      wait_pulse("held_msi_pulse");
      mie = 1'b0; cpu_stat_ex = 1'b0;
      step(2);

      // Hold then cancel by clearing msip
      mie = 1'b1;
      step(3);
      bus_write(ADR_MSIP, 0);
      cpu_stat_ex = 1'b1;
      step(10);
      chk("cancel_msip", {31'd0, mip[0]}, 0, 0);
      mie = 1'b0; cpu_stat_ex = 1'b0;

      // Reset while held in ISSUE
      bus_write(ADR_MSIP, 1);
      mie = 1'b1;
      step(3);
      rst = 1'b1; cpu_stat_ex = 1'b1;
      @(negedge clk);
      chk("rst_issue_no_pulse", {31'd0, g_int}, 0, 0);
      step(1);
      rst = 1'b0;
      step(4);
      chk("rst_issue_cause", {28'd0, cause}, 0, 0);
      chk("rst_issue_mip", {29'd0, mip}, 0, 0);
      mie = 1'b0; cpu_stat_ex = 1'b0;

      // msip / unmapped address decode
      bus_write(ADR_MSIP, 32'hFFFF_FFFF);
      bus_read(ADR_MSIP, 1, 1, 1'b0, "msip_read");
      bus_write(ADR_MSIP, 0);
      bus_write(3'd5, 32'hDEAD_BEEF);
      bus_read(3'd5, 0, 0, 1'b0, "adr5_zero");
      bus_read(3'd7, 0, 0, 1'b0, "adr7_zero");

      // Tick/write collision: lo write beats tick, no carry into hi
      bus_write(ADR_MTIME_HI, 5);
      bus_write(ADR_MTIME_LO, 32'hFFFF_FFFF);
      bus_write(ADR_MTIME_LO, 32'h100);
      bus_read(ADR_MTIME_LO, 32'h100, 32'h100, 1'b0, "collide_lo");
      bus_read(ADR_MTIME_HI, 5, 5, 1'b0, "collide_hi");

      // Prescaler (TICK_DIV = 4) and 64-bit wrap
      bus_write(ADR_MTIME_HI, 32'hFFFF_FFFF);
      bus_write(ADR_MTIME_LO, 32'hFFFF_FFFE);
      bus_read(ADR_MTIME_LO, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b1, "div4_pre");
      step(7);
      bus_read(ADR_MTIME_LO, 0, 0, 1'b1, "div4_wrap_lo");
      bus_read(ADR_MTIME_HI, 0, 0, 1'b1, "div4_wrap_hi");

      step(4);
      checks++;
      if (rd_q.size() != 0 || int_q.size() != 0) begin
         errors++;
         $display("FAIL queues_drained: got %0d reads %0d pulses left, want 0 0",
                  rd_q.size(), int_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
